loop_sampler: RTL
=================

LOOP_SAMPLER -- requirements
Module: loop_sampler

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and reset_n.
REQ-002 Parameter SEED_CYCLES, default 4: cycles loop_ctrl is held high per seeding.
REQ-003 Parameter WARMUP_CYCLES, default 64: free-run cycles after seeding before any sample is used.
REQ-004 Parameter SAMPLE_DIV, default 16: clk cycles between consecutive raw samples, legal range 2..255.
REQ-005 Parameter STUCK_LIMIT, default 32: consecutive discarded pairs that flag a stuck loop.
REQ-006 clk  input  1  system clock.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 enable  input  1  high runs the sampler; low returns it to IDLE.
REQ-009 loop_ctrl  output  1  drives the ring oscillator ctrl input; high forces the seed value.
REQ-010 loop_seed  output  1  drives the ring oscillator seed input.
REQ-011 loop_d  input  1  asynchronous ring oscillator output.
REQ-012 data  output  32  collected entropy word.
REQ-013 data_valid  output  1  data holds a complete word.
REQ-014 data_ack  input  1  consumer accepts data.
REQ-015 stuck_error  output  1  sticky stuck-loop flag.

Function
REQ-016 loop_d SHALL pass through a 2-flop synchronizer; all uses refer to the synchronized bit, giving 2 cycles of latency.
REQ-017 States: IDLE, SEED, WARMUP, COLLECT, FULL.
REQ-018 IDLE: loop_ctrl=1, and no sampling; enable=1 moves to SEED.
REQ-019 SEED: loop_ctrl=1 for exactly SEED_CYCLES cycles, then go to WARMUP.
REQ-020 WARMUP: loop_ctrl=0 for WARMUP_CYCLES cycles, then go to COLLECT with the sample divider cleared.
REQ-021 COLLECT: take one raw sample every SAMPLE_DIV cycles; raw samples pair as (first, second).
REQ-022 Debias pairs: 01 emits bit 0, 10 emits bit 1, and 00 or 11 emits nothing.
REQ-023 Each emitted bit SHALL shift into data LSB-first (data <= {data[30:0], bit}); the 32nd emitted bit moves to FULL with data_valid=1 on the next cycle.
REQ-024 FULL: data and data_valid hold stable; the loop keeps running; sampling pauses.
REQ-025 data_valid=1 with data_ack=1 consumes the word, clears data_valid the next cycle, clears the bit counter, and returns to COLLECT.
REQ-026 data_ack while data_valid=0 SHALL be ignored.
REQ-027 Discarded-pair counter: it increments on each 00/11 pair, clears on any emitted bit, and saturates at STUCK_LIMIT.
REQ-028 When the counter reaches STUCK_LIMIT, set stuck_error, toggle loop_seed, clear the partial word, and go to SEED.
REQ-029 stuck_error SHALL clear only on enable=0 or reset.
REQ-030 enable=0 in any state SHALL go to IDLE next cycle and clear data_valid, the partial word, the bit counter and the stuck_error flag, and drive loop_ctrl=1; a word not yet acknowledged is lost.
REQ-031 enable=0 and data_ack=1 in the same cycle: enable has priority.

Reset
REQ-032 Reset values: state=IDLE, loop_ctrl=1, loop_seed=0, data=0, data_valid=0, stuck_error=0, all counters 0, synchronizer flops 0.
REQ-033 Reset asserted mid-operation SHALL take effect immediately and asynchronously, with no word output.

Structure
REQ-034 Shared package loop_sampler_pkg: state encoding constants, parameter defaults, and word width 32.
REQ-035 One sub-module, sync2, SHALL implement the 2-flop synchronizer; the FSM, counters and debias logic stay in loop_sampler.

Verification
REQ-036 Reset, then enable=1 -> loop_ctrl high for exactly 4 cycles, then low; no sample is taken within the following 64 cycles.
REQ-037 Model loop_d so raw pairs alternate 01,10 repeatedly -> data_valid rises after 32 pairs with data=32'h55555555.
REQ-038 Word pending, data_ack held low for 500 cycles -> data stable and no sampling; then a 1-cycle data_ack -> data_valid=0 the next cycle and collection resumes.
REQ-039 loop_d held at constant 1 -> after 32 discarded pairs, stuck_error=1, loop_seed toggles to 1, and SEED is re-entered; then enable=0 -> stuck_error=0.
REQ-040 enable=0 mid-COLLECT with 17 bits gathered -> IDLE next cycle; re-enable, the next word is built from fresh bits only.
REQ-041 reset_n pulsed low while in FULL -> all outputs return to their reset values at once.

Source files
------------

// File: rtl/loop_sampler_pkg.sv
// Shared types, defaults and helpers for the ring-oscillator entropy sampler.
package loop_sampler_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned BITCNT_W = $clog2(WORD_W + 1);
    localparam int unsigned DIV_W    = 8;

    localparam int unsigned SEED_CYCLES_DEF   = 4;
    localparam int unsigned WARMUP_CYCLES_DEF = 64;
    localparam int unsigned SAMPLE_DIV_DEF    = 16;
    localparam int unsigned STUCK_LIMIT_DEF   = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEED    = 3'd1,
        ST_WARMUP  = 3'd2,
        ST_COLLECT = 3'd3,
        ST_FULL    = 3'd4
    } state_e;

    typedef struct packed {
        logic valid;
        logic value;
    } debias_t;

    // Von Neumann debias: 01 -> 0, 10 -> 1, equal pairs carry no entropy.
    function automatic debias_t debias(input logic first, input logic second);
        debias_t r;
        r.valid = first ^ second;
        r.value = first;
        return r;
    endfunction

endpackage

// File: rtl/loop_sampler_sync2.sv
// Two-flop synchronizer for the free-running ring oscillator output.
module sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/loop_sampler.sv
// Ring-oscillator entropy sampler: seeds and warms the loop, samples it at a
// fixed divider, debiases sample pairs and assembles 32-bit words.
module loop_sampler
    import loop_sampler_pkg::*;
#(
    parameter int unsigned SEED_CYCLES   = SEED_CYCLES_DEF,
    parameter int unsigned WARMUP_CYCLES = WARMUP_CYCLES_DEF,
    parameter int unsigned SAMPLE_DIV    = SAMPLE_DIV_DEF,
    parameter int unsigned STUCK_LIMIT   = STUCK_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    output logic              loop_ctrl,
    output logic              loop_seed,
    input  logic              loop_d,
    output logic [WORD_W-1:0] data,
    output logic              data_valid,
    input  logic              data_ack,
    output logic              stuck_error
);

    localparam int unsigned CNT_MAX = (SEED_CYCLES > WARMUP_CYCLES) ? SEED_CYCLES : WARMUP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned DISC_W  = $clog2(STUCK_LIMIT + 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [DISC_W-1:0]   disc_q, disc_d;
    logic [BITCNT_W-1:0] bitcnt_q, bitcnt_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic                have_first_q, have_first_d;
    logic                first_q, first_d;
    logic                valid_q, valid_d;
    logic                stuck_q, stuck_d;
    logic                seed_q, seed_d;
    logic                loop_ctrl_q, loop_ctrl_d;

    logic                loop_sync;
    debias_t             pair_c;

    sync2 u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (loop_d),
        .q_o     (loop_sync)
    );

    assign pair_c = debias(first_q, loop_sync);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            div_q        <= '0;
            disc_q       <= '0;
            bitcnt_q     <= '0;
            data_q       <= '0;
            have_first_q <= 1'b0;
            first_q      <= 1'b0;
            valid_q      <= 1'b0;
            stuck_q      <= 1'b0;
            seed_q       <= 1'b0;
            loop_ctrl_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            disc_q       <= disc_d;
            bitcnt_q     <= bitcnt_d;
            data_q       <= data_d;
            have_first_q <= have_first_d;
            first_q      <= first_d;
            valid_q      <= valid_d;
            stuck_q      <= stuck_d;
            seed_q       <= seed_d;
            loop_ctrl_q  <= loop_ctrl_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        div_d        = div_q;
        disc_d       = disc_q;
        bitcnt_d     = bitcnt_q;
        data_d       = data_q;
        have_first_d = have_first_q;
        first_d      = first_q;
        valid_d      = valid_q;
        stuck_d      = stuck_q;
        seed_d       = seed_q;
        loop_ctrl_d  = loop_ctrl_q;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d        = '0;
                div_d        = '0;
                disc_d       = '0;
                have_first_d = 1'b0;
                if (enable) begin
                    state_d = ST_SEED;
                end
            end

            ST_SEED: begin
                if (cnt_q == CNT_W'(SEED_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_WARMUP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_WARMUP: begin
                if (cnt_q == CNT_W'(WARMUP_CYCLES - 1)) begin
                    cnt_d        = '0;
                    div_d        = '0;
                    disc_d       = '0;
                    have_first_d = 1'b0;
                    state_d      = ST_COLLECT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_COLLECT: begin
                if (div_q == DIV_W'(SAMPLE_DIV - 1)) begin
                    div_d = '0;
                    if (!have_first_q) begin
                        first_d      = loop_sync;
                        have_first_d = 1'b1;
                    end else begin
                        have_first_d = 1'b0;
                        if (pair_c.valid) begin
                            data_d   = {data_q[WORD_W-2:0], pair_c.value};
                            disc_d   = '0;
                            bitcnt_d = bitcnt_q + BITCNT_W'(1);
                            if (bitcnt_q == BITCNT_W'(WORD_W - 1)) begin
                                valid_d = 1'b1;
                                state_d = ST_FULL;
                            end
                        end else if (disc_q == DISC_W'(STUCK_LIMIT - 1)) begin
                            // Loop looks frozen: flag it, flip the seed and reseed.
                            disc_d   = DISC_W'(STUCK_LIMIT);
                            stuck_d  = 1'b1;
                            seed_d   = ~seed_q;
                            data_d   = '0;
                            bitcnt_d = '0;
                            cnt_d    = '0;
                            state_d  = ST_SEED;
                        end else begin
                            disc_d = disc_q + DISC_W'(1);
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            ST_FULL: begin
                if (valid_q && data_ack) begin
                    valid_d      = 1'b0;
                    bitcnt_d     = '0;
                    div_d        = '0;
                    have_first_d = 1'b0;
                    state_d      = ST_COLLECT;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Dropping enable wins over everything, including a same-cycle ack.
        if (!enable) begin
            state_d      = ST_IDLE;
            cnt_d        = '0;
            div_d        = '0;
            disc_d       = '0;
            bitcnt_d     = '0;
            data_d       = '0;
            have_first_d = 1'b0;
            valid_d      = 1'b0;
            stuck_d      = 1'b0;
        end

        loop_ctrl_d = (state_d == ST_IDLE) || (state_d == ST_SEED);
    end

    assign loop_ctrl   = loop_ctrl_q;
    assign loop_seed   = seed_q;
    assign data        = data_q;
    assign data_valid  = valid_q;
    assign stuck_error = stuck_q;

endmodule
